// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the memory-stage SRAM controller.
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} mem_state_e;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits each 32-bit load/store into two 16-bit async SRAM accesses,
// stalling the pipeline through ready until the transaction completes.
module sram_mem_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    mem_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_AW-2:0] word;
    logic req, last, drive;

    // Word index of the rebased byte address; the byte offset and upper bits drop out.
    assign word  = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);
    assign req   = rd_en | wr_en;
    assign last  = cnt_q == LAST;
    assign drive = wr_q & (state_q == LOW | state_q == HIGH);

    assign ready     = (state_q == IDLE & ~req) | state_q == DONE;
    assign read_data = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = ~drive;
    assign SRAM_DQ   = drive ? (state_q == HIGH ? wdata_q[31:16] : wdata_q[15:0]) : 'z;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
        end
    end

    // SRAM_ADDR is registered and loaded one edge early so it is valid for the whole phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = LOW;
                cnt_d   = '0;
                wr_d    = wr_en;
                wdata_d = write_data;
                addr_d  = {word, 1'b0};
            end
            LOW: begin
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    addr_d  = {addr_q[SRAM_AW-1:1], 1'b1};
                    if (!wr_q) rdata_d[15:0] = SRAM_DQ;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!wr_q) rdata_d[31:16] = SRAM_DQ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: scoreboard bench with behavioural SRAMs for A=2 (dut0) and A=1 (dut1).
module tb_sram_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] address [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data [2];
    logic        ready [2];
    logic        we_n [2];
    logic [17:0] sram_addr [2];
    logic        ub_n [2], lb_n [2], ce_n [2], oe_n [2];
    wire  [15:0] dq0, dq1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    logic [31:0] refm [int];
    logic [31:0] sb [$];
    logic        trace [$];
    logic [31:0] last_rd [2];
    int          we_low [2];
    int          compared = 0;
    int          failed = 0;

    sram_mem_ctrl #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .address(address[0]),
        .write_data(write_data[0]), .read_data(read_data[0]), .ready(ready[0]), .SRAM_DQ(dq0),
        .SRAM_ADDR(sram_addr[0]), .SRAM_WE_N(we_n[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]),
        .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0])
    );

    sram_mem_ctrl #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .address(address[1]),
        .write_data(write_data[1]), .read_data(read_data[1]), .ready(ready[1]), .SRAM_DQ(dq1),
        .SRAM_ADDR(sram_addr[1]), .SRAM_WE_N(we_n[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]),
        .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1])
    );

    // Asynchronous SRAM models: combinational read, write while WE_N is low.
    assign dq0 = we_n[0] ? mem0[sram_addr[0]] : 16'hzzzz;
    assign dq1 = we_n[1] ? mem1[sram_addr[1]] : 16'hzzzz;
    always @(posedge clk) if (!we_n[0]) mem0[sram_addr[0]] <= dq0;
    always @(posedge clk) if (!we_n[1]) mem1[sram_addr[1]] <= dq1;
    always @(negedge clk) begin
        if (!we_n[0]) we_low[0] <= we_low[0] + 1;
        if (!we_n[1]) we_low[1] <= we_low[1] + 1;
    end

    task automatic access(input int s, input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input int exp_stall);
        int key, stalls;
        bit done;
        logic [31:0] exp;
        key = (s << 20) | int'(((a - 32'd1024) >> 2) & 32'h1ffff);
        rd_en[s] = rd;
        wr_en[s] = wr;
        address[s] = a;
        write_data[s] = d;
        if (wr) refm[key] = d;
        else if (rd) sb.push_back(refm.exists(key) ? refm[key] : 32'h0);
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            trace.push_back(ready[s]);
            if (ready[s]) done = 1'b1;
            else stalls++;
        end
        compared++;
        if (!done || stalls != exp_stall) begin
            failed++;
            $display("FAIL stall_count dut%0d addr=%h: got %0d stall cycles (done=%0d), expected %0d",
                     s, a, stalls, done, exp_stall);
        end
        exp = (!wr && rd) ? sb.pop_front() : last_rd[s];
        if (done) begin
            compared++;
            if (read_data[s] !== exp) begin
                failed++;
                $display("FAIL read_data dut%0d addr=%h: got %h, expected %h", s, a, read_data[s], exp);
            end
        end
        last_rd[s] = exp;
        @(posedge clk);
        #1;
        rd_en[s] = 1'b0;
        wr_en[s] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            compared += 4;
            if (ready[s] !== 1'b1) begin failed++; $display("FAIL reset_ready dut%0d: got %b, expected 1", s, ready[s]); end
            if (read_data[s] !== 32'h0) begin failed++; $display("FAIL reset_rdata dut%0d: got %h, expected 0", s, read_data[s]); end
            if (we_n[s] !== 1'b1) begin failed++; $display("FAIL reset_we_n dut%0d: got %b, expected 1", s, we_n[s]); end
            if (sram_addr[s] !== 18'h0) begin failed++; $display("FAIL reset_addr dut%0d: got %h, expected 0", s, sram_addr[s]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 5);
        compared += 2;
        if (mem0[0] !== 16'hBEEF) begin failed++; $display("FAIL sram_lo: got %h, expected beef", mem0[0]); end
        if (mem0[1] !== 16'hDEAD) begin failed++; $display("FAIL sram_hi: got %h, expected dead", mem0[1]); end
        access(0, 1'b0, 1'b1, 32'd1024, 32'h0, 5);
    endtask

    task automatic test_addressing();
        access(0, 1'b1, 1'b0, 32'd1032, 32'h12345678, 5);
        compared += 2;
        if (mem0[4] !== 16'h5678) begin failed++; $display("FAIL addr_lo: got %h, expected 5678", mem0[4]); end
        if (mem0[5] !== 16'h1234) begin failed++; $display("FAIL addr_hi: got %h, expected 1234", mem0[5]); end
        access(0, 1'b0, 1'b1, 32'd1034, 32'h0, 5);
    endtask

    task automatic test_back_to_back();
        logic [11:0] pat;
        int n;
        trace.delete();
        access(0, 1'b1, 1'b0, 32'd1040, 32'hA5A55A5A, 5);
        access(0, 1'b0, 1'b1, 32'd1040, 32'h0, 5);
        pat = '0;
        n = trace.size();
        foreach (trace[i]) pat = {pat[10:0], trace[i]};
        compared++;
        if (n != 12 || pat !== 12'b0000_0100_0001) begin
            failed++;
            $display("FAIL b2b_ready: got %0d samples pattern %b, expected 12 samples 000001000001", n, pat);
        end
    endtask

    task automatic test_rd_wr_both();
        int w0;
        w0 = we_low[0];
        access(0, 1'b1, 1'b1, 32'd1048, 32'h0BADCAFE, 5);
        compared += 3;
        if (we_low[0] - w0 != 4) begin failed++; $display("FAIL both_we_pulse: got %0d low cycles, expected 4", we_low[0] - w0); end
        if (mem0[12] !== 16'hCAFE) begin failed++; $display("FAIL both_lo: got %h, expected cafe", mem0[12]); end
        if (mem0[13] !== 16'h0BAD) begin failed++; $display("FAIL both_hi: got %h, expected 0bad", mem0[13]); end
        access(0, 1'b0, 1'b1, 32'd1048, 32'h0, 5);
    endtask

    task automatic test_reset_mid();
        rd_en[0] = 1'b1;
        address[0] = 32'd1032;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        compared++;
        if (ready[0] !== 1'b0) begin failed++; $display("FAIL rstmid_ready_req: got %b, expected 0", ready[0]); end
        rd_en[0] = 1'b0;
        #1;
        compared += 5;
        if (ready[0] !== 1'b1) begin failed++; $display("FAIL rstmid_ready: got %b, expected 1", ready[0]); end
        if (read_data[0] !== 32'h0) begin failed++; $display("FAIL rstmid_rdata: got %h, expected 0", read_data[0]); end
        if (we_n[0] !== 1'b1) begin failed++; $display("FAIL rstmid_we_n: got %b, expected 1", we_n[0]); end
        if (sram_addr[0] !== 18'h0) begin failed++; $display("FAIL rstmid_addr: got %h, expected 0", sram_addr[0]); end
        if (dq0 !== mem0[0]) begin failed++; $display("FAIL rstmid_dq: got %h, expected %h", dq0, mem0[0]); end
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        access(0, 1'b0, 1'b1, 32'd1032, 32'h0, 5);
    endtask

    task automatic test_access1();
        access(1, 1'b1, 1'b0, 32'd1280, 32'hCAFEF00D, 3);
        compared += 2;
        if (mem1[128] !== 16'hF00D) begin failed++; $display("FAIL a1_lo: got %h, expected f00d", mem1[128]); end
        if (mem1[129] !== 16'hCAFE) begin failed++; $display("FAIL a1_hi: got %h, expected cafe", mem1[129]); end
        access(1, 1'b0, 1'b1, 32'd1280, 32'h0, 3);
        access(1, 1'b1, 1'b0, 32'd1284, 32'h13579BDF, 3);
        access(1, 1'b0, 1'b1, 32'd1284, 32'h0, 3);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rd_en[s] = 1'b0;
            wr_en[s] = 1'b0;
            address[s] = 32'h0;
            write_data[s] = 32'h0;
            last_rd[s] = 32'h0;
            we_low[s] = 0;
        end
        test_reset();
        test_store_load();
        test_addressing();
        test_back_to_back();
        test_rd_wr_both();
        test_access1();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-stage data-memory controller between the EXE/MEM and MEM/WB pipeline registers. It turns each 32-bit load or store from the memory stage into two 16-bit accesses on the board's external asynchronous SRAM. Its `ready` output freezes every pipeline register and the PC while a transaction is in flight. Load data leaves on `read_data` and becomes the memory-stage `mem_out` captured by MEM/WB.

## Interface
Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ACCESS_CYCLES, 2: clock cycles each 16-bit SRAM access is held (≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  1  load request (MEM_R_EN of the memory-stage instruction).
- wr_en  in  1  store request (MEM_W_EN).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  load result, registered.
- ready  out  1  1 = no pending access; 0 = freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus; high-Z unless writing.
- SRAM_ADDR  out  18  SRAM halfword address.
- SRAM_WE_N  out  1  write enable, active-low.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.

## Operation
- States: IDLE, LOW, HIGH, DONE. A cycle counter `cnt` is used in LOW and HIGH.
- IDLE:
  - If rd_en|wr_en, latch the operation, address and write_data, clear `cnt`, and go to LOW.
  - wr_en has priority if both are asserted; that is a store only.
- Address mapping: off = address − BASE_ADDR (32-bit wrap); word index w = off[18:2]. off[1:0] and off[31:19] are ignored.
- LOW:
  - SRAM_ADDR = {w,1'b0}.
  - Store: DQ driven with wdata[15:0] and SRAM_WE_N=0.
  - Load: DQ is high-Z; rdata[15:0] ← DQ on the last edge of LOW.
  - Stays ACCESS_CYCLES cycles, then goes to HIGH with `cnt` cleared.
- HIGH: same as LOW with SRAM_ADDR = {w,1'b1} and bits [31:16]. Goes to DONE after ACCESS_CYCLES cycles.
- DONE: lasts one cycle, then goes to IDLE unconditionally.
- ready = (IDLE & ~rd_en & ~wr_en) | DONE. This is combinational so the freeze takes effect in the request cycle itself.
- read_data:
  - Holds its value through stores and idle cycles.
  - Valid from DONE until overwritten by the next load's LOW capture.
- Outside LOW/HIGH of a store: SRAM_WE_N=1, DQ high-Z, SRAM_ADDR holds its last value (0 after reset).

## Timing
- Latency, request at cycle 0:
  - LOW occupies cycles 1..A, HIGH cycles A+1..2A, DONE cycle 2A+1 (A = ACCESS_CYCLES).
  - ready is low in cycles 0..2A and high in cycle 2A+1. With the default A=2 that is 5 stall cycles.
- In DONE the pipeline advances, so MEM/WB captures read_data at the end of cycle 2A+1.
- A request presented in the cycle after DONE starts a new transaction immediately, with no bubble.
- Request inputs are only sampled in IDLE. Changes during LOW/HIGH/DONE are ignored; the pipeline is frozen in those states.
- Reset at any time, including mid-transaction:
  - state=IDLE, cnt=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, DQ high-Z.
  - A partially written word stays partially written; this is accepted.
- Release from reset with rd_en=1 starts a load on the first clock edge.

## Structure
- Shared package (`cpu_pkg`) holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - SRAM_AW=18 and SRAM_DW=16;
  - the default BASE_ADDR.
- Single module with no sub-module. The tristate is a continuous assign on SRAM_DQ gated by (store & state∈{LOW,HIGH}).
- The bench provides an SRAM behavioural model: 256K×16 array, combinational read, write on WE_N low.

## Test plan
- Store then load: store 0xDEADBEEF at 1024, then load 1024.
  - SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
  - read_data=0xDEADBEEF in DONE; ready low exactly 5 cycles per access.
- Addressing: store 0x12345678 at 1032.
  - Writes land at SRAM_ADDR 4 and 5.
  - A load at 1034 (low bits ignored) returns 0x12345678.
- Back-to-back: a load in the cycle right after DONE of a store starts LOW next cycle with no idle gap. Assert the ready pattern 0,0,0,0,0,1,0,0,0,0,0,1.
- rd_en and wr_en both asserted: a store is performed. read_data keeps its previous value and SRAM_WE_N pulses low.
- Reset in HIGH of a load:
  - Next cycle: state IDLE, ready=~(rd_en|wr_en), read_data=0, WE_N=1, DQ high-Z.
  - A following load completes normally.
- ACCESS_CYCLES=1 build: store+load round-trip with 3 stall cycles per access, and data correct.
